// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and a small decode helper used by the core and the decode stage.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MUL  = 2'b00,
    MULH = 2'b01,
    DIV  = 2'b10,
    REM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic is_div_op(input op_e o);
    return (o == DIV) || (o == REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, sharing one 2*WIDTH accumulator and counter.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state, next_state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mag;
  op_e                op_q;
  logic               neg_q;
  logic               rem_neg_q;
  logic [WIDTH-1:0]   result_q;
  logic               dbz_q;

  logic               accept;
  op_e                op_in;
  logic               div_in;
  logic               b_zero;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     trial;
  logic               trial_ge;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem_w;
  logic [WIDTH-1:0]   fix_value;

  assign in_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign out_valid   = (state == DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

  assign accept = in_valid && in_ready;
  assign op_in  = op_e'(op);
  assign div_in = is_div_op(op_in);
  assign b_zero = (b == '0);
  assign a_neg  = is_signed & a[WIDTH-1];
  assign b_neg  = is_signed & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  // One iteration of each algorithm; mag holds the multiplicand or divisor.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag};
  assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
  assign trial    = acc[2*WIDTH-1:WIDTH-1];
  assign trial_ge = (trial >= {1'b0, mag});
  assign diff     = trial[WIDTH-1:0] - mag;
  assign div_next = trial_ge ? {diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};

  assign prod_fix = neg_q ? -acc : acc;
  assign quo      = acc[WIDTH-1:0];
  assign rem_w    = acc[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_value = prod_fix[WIDTH-1:0];
    case (op_q)
      MUL:     fix_value = prod_fix[WIDTH-1:0];
      MULH:    fix_value = prod_fix[2*WIDTH-1:WIDTH];
      DIV:     fix_value = neg_q ? -quo : quo;
      default: fix_value = rem_neg_q ? -rem_w : rem_w;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Kill aborts any in-flight state; in IDLE a simultaneous request still wins.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (div_in && b_zero) ? DONE : CALC;
      CALC: begin
        if (kill)               next_state = IDLE;
        else if (count == LAST) next_state = FIX;
      end
      FIX:  next_state = kill ? IDLE : DONE;
      DONE: if (kill || out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      acc       <= '0;
      mag       <= '0;
      op_q      <= MUL;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q      <= op_in;
          count     <= '0;
          neg_q     <= a_neg ^ b_neg;
          rem_neg_q <= a_neg;
          dbz_q     <= div_in && b_zero;
          if (div_in) begin
            acc <= {{WIDTH{1'b0}}, a_mag};
            mag <= b_mag;
            if (b_zero) result_q <= (op_in == REM) ? a : '1;
          end else begin
            acc <= {{WIDTH{1'b0}}, b_mag};
            mag <= a_mag;
          end
        end
        CALC: begin
          acc   <= is_div_op(op_q) ? div_next : mul_next;
          count <= count + CW'(1);
        end
        FIX:  result_q <= fix_value;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width (>=4, even).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request presented.
REQ-005 in_ready  output  1  unit can accept request (high only in IDLE).
REQ-006 op  input  2  00 MUL (low word), 01 MULH (high word), 10 DIV, 11 REM.
REQ-007 is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 a  input  WIDTH  multiplicand / dividend.
REQ-009 b  input  WIDTH  multiplier / divisor.
REQ-010 kill  input  1  abort in-flight operation (pipeline flush).
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  WIDTH  selected result word.
REQ-014 div_by_zero  output  1  qualifies result; set for DIV/REM with b==0.
REQ-015 busy  output  1  high in any state other than IDLE (pipeline stall).

Function
REQ-016 FSM states: IDLE, CALC, FIX, DONE.
REQ-017 Accept on rising edge when in_valid && in_ready; a, b, op and is_signed are captured and not resampled afterwards.
REQ-018 IDLE->CALC on accept; exception: DIV/REM with b==0 goes IDLE->DONE directly.
REQ-019 CALC runs exactly WIDTH cycles, one iteration per cycle, tracked by an iteration counter of clog2(WIDTH)+1 bits; CALC->FIX when the counter reaches WIDTH-1.
REQ-020 MUL/MULH: radix-2 shift-add on operand magnitudes into a 2*WIDTH accumulator.
REQ-021 DIV/REM: restoring division on magnitudes; quotient WIDTH bits, remainder WIDTH bits.
REQ-022 Signed mode: magnitudes taken at accept; in FIX, product negated if sign(a)!=sign(b), quotient negated if sign(a)!=sign(b), remainder takes the sign of a.
REQ-023 Unsigned mode: FIX applies no correction.
REQ-024 FIX->DONE unconditionally after 1 cycle; out_valid rises WIDTH+2 cycles after the accepting edge.
REQ-025 MUL returns product[WIDTH-1:0]; MULH returns product[2*WIDTH-1:WIDTH].
REQ-026 Division by zero: DIV result all ones, REM result = a, div_by_zero=1; out_valid rises 1 cycle after accept.
REQ-027 Signed overflow (a = most-negative value, b = -1): DIV returns the most-negative value, REM returns 0, div_by_zero=0.
REQ-028 In DONE, result, div_by_zero and out_valid hold stable until out_ready is sampled high; DONE->IDLE on that edge.
REQ-029 in_ready=0 in DONE; no new request is accepted in the cycle result is consumed (one-cycle bubble).
REQ-030 kill=1 in CALC, FIX or DONE: return to IDLE next edge, out_valid=0 next cycle, result discarded; kill in IDLE has no effect; kill and in_valid in the same IDLE cycle: request is accepted.
REQ-031 div_by_zero=0 for all MUL/MULH results.

Reset
REQ-032 reset takes priority over kill and all handshakes: state=IDLE, counter=0, out_valid=0, result=0, div_by_zero=0, busy=0, in_ready=1 after the edge.
REQ-033 reset asserted mid-CALC discards the operation; no out_valid pulse follows.

Structure
REQ-034 Shared package muldiv_pkg holds the op encodings (MUL, MULH, DIV, REM) and the FSM state encoding; the core and the pipeline decode stage both import it.
REQ-035 Single module; no sub-module; the multiply and divide datapaths share the 2*WIDTH accumulator and the iteration counter.

Verification (WIDTH=32)
REQ-036 MUL unsigned a=7, b=6 -> result=42, out_valid exactly 34 cycles after accept.
REQ-037 MULH signed a=b=0xFFFFFFFF -> result=0x00000000; MUL on the same operands -> 0x00000001.
REQ-038 DIV signed a=-7, b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV a=0x80000000, b=-1 -> 0x80000000, REM 0.
REQ-039 DIV a=5, b=0 -> result=0xFFFFFFFF, div_by_zero=1, out_valid 1 cycle after accept; REM on the same operands -> 5.
REQ-040 out_ready held low 5 cycles in DONE -> result stable and in_ready=0 throughout; next accept possible 1 cycle after consumption.
REQ-041 kill at CALC cycle 10 (and separately reset at CALC cycle 10) -> IDLE next cycle, no out_valid, new request then completes correctly.
